// File: rtl/shop_arbiter_pkg.sv
// shop_arbiter_pkg: shared state encoding, widths, level cap and default prices for the shop arbiter.
package shop_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMMIT} state_t;
    localparam int COST_W = 12;
    localparam int LVL_W = 2;
    localparam logic [LVL_W-1:0] MAX_LEVEL = 2'd3;
    localparam logic [COST_W-1:0] BASE_COST0_DEF = 12'd10;
    localparam logic [COST_W-1:0] BASE_COST1_DEF = 12'd50;
    localparam logic [COST_W-1:0] BASE_COST2_DEF = 12'd200;
    localparam logic [COST_W-1:0] BASE_COST3_DEF = 12'd500;

    // Price doubles per level; overflow past the cost width is simply dropped.
    function automatic logic [COST_W-1:0] scaled_cost(input logic [COST_W-1:0] base, input logic [LVL_W-1:0] lvl);
        return base << lvl;
    endfunction
endpackage

// File: rtl/rr_select_4.sv
// rr_select_4: round-robin pick of one pending requester out of four, searching upward from rrPtr.
module rr_select_4 (
    input  logic [3:0] pending,
    input  logic [1:0] rrPtr,
    output logic       grantValid,
    output logic [1:0] grantIdx
);
    logic [3:0] rot;
    logic [1:0] off;
    always_comb begin
        rot = 4'({pending, pending} >> rrPtr);
        off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
        grantValid = |pending;
        grantIdx = rrPtr + off;
    end
endmodule

// File: rtl/shop_arbiter.sv
// shop_arbiter: round-robin upgrade-purchase arbiter that prices items by level and talks to a wallet.
module shop_arbiter
    import shop_arbiter_pkg::*;
#(
    parameter int                NUM_ITEMS    = 4,
    parameter logic [COST_W-1:0] BASE_COST0   = BASE_COST0_DEF,
    parameter logic [COST_W-1:0] BASE_COST1   = BASE_COST1_DEF,
    parameter logic [COST_W-1:0] BASE_COST2   = BASE_COST2_DEF,
    parameter logic [COST_W-1:0] BASE_COST3   = BASE_COST3_DEF,
    parameter int                RESP_TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_ITEMS-1:0]   req,
    input  logic                   buySucc,
    output logic                   purchase,
    output logic [COST_W-1:0]      unitCost,
    output logic [1:0]             itemSel,
    output logic [2*NUM_ITEMS-1:0] levels,
    output logic                   busy,
    output logic                   buyOk,
    output logic                   buyFail
);
    localparam logic [COST_W-1:0] BASE [4] = '{BASE_COST0, BASE_COST1, BASE_COST2, BASE_COST3};
    localparam logic [7:0] TO_LAST = 8'(RESP_TIMEOUT - 1);

    state_t state;
    logic [3:0] pending, clr;
    logic [1:0] rr_ptr, grant_idx;
    logic grant_valid;
    logic [7:0] cnt;
    logic [LVL_W-1:0] grant_lvl, sel_lvl;

    rr_select_4 u_rr (
        .pending    (pending),
        .rrPtr      (rr_ptr),
        .grantValid (grant_valid),
        .grantIdx   (grant_idx)
    );

    always_comb begin
        grant_lvl = levels[{grant_idx, 1'b0} +: LVL_W];
        sel_lvl = levels[{itemSel, 1'b0} +: LVL_W];
        clr = (state == IDLE && grant_valid) ? 4'b0001 << grant_idx : 4'b0000;
    end

    assign busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pending <= '0;
            rr_ptr <= '0;
            levels <= '0;
            cnt <= '0;
            purchase <= 1'b0;
            buyOk <= 1'b0;
            buyFail <= 1'b0;
            itemSel <= '0;
            unitCost <= '0;
        end else begin
            purchase <= 1'b0;
            buyOk <= 1'b0;
            buyFail <= 1'b0;
            // A fresh request on the bit being granted keeps it pending.
            pending <= (pending & ~clr) | req;
            case (state)
                IDLE: if (grant_valid) begin
                    rr_ptr <= grant_idx + 2'd1;
                    if (grant_lvl == MAX_LEVEL) buyFail <= 1'b1;
                    else begin
                        state <= ISSUE;
                        itemSel <= grant_idx;
                        unitCost <= scaled_cost(BASE[grant_idx], grant_lvl);
                        purchase <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    cnt <= '0;
                end
                WAIT: if (buySucc) state <= COMMIT;
                else if (cnt == TO_LAST) begin
                    state <= IDLE;
                    buyFail <= 1'b1;
                    itemSel <= '0;
                    unitCost <= '0;
                    cnt <= '0;
                end else cnt <= cnt + 8'd1;
                COMMIT: begin
                    levels[{itemSel, 1'b0} +: LVL_W] <= (sel_lvl == MAX_LEVEL) ? sel_lvl : sel_lvl + 2'd1;
                    buyOk <= 1'b1;
                    state <= IDLE;
                    itemSel <= '0;
                    unitCost <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shop_arbiter.sv
// tb_shop_arbiter: directed scenarios plus random traffic, every cycle compared against a transaction-level model.
module tb_shop_arbiter;
    localparam int TO = 8;
    localparam int BASE_T [4] = '{10, 50, 200, 500};

    logic clk, rst, buySucc, purchase, busy, buyOk, buyFail;
    logic [3:0] req;
    logic [11:0] unitCost;
    logic [1:0] itemSel;
    logic [7:0] levels;

    shop_arbiter #(.RESP_TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .buySucc  (buySucc),
        .purchase (purchase),
        .unitCost (unitCost),
        .itemSel  (itemSel),
        .levels   (levels),
        .busy     (busy),
        .buyOk    (buyOk),
        .buyFail  (buyFail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit [3:0] mp;
    int ml [4];
    int mptr, age, msel, mcost;
    bit txn, acked, e_purch, e_ok, e_fail;
    int sel_q [$], cost_q [$];
    int nfail, nok, cyc, p_cyc, f_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Model: pending set, level table, pointer, and an in-flight transaction aged in cycles.
    task automatic model_step(input logic [3:0] r, input logic s, input logic rs);
        int g;
        g = -1;
        e_purch = 0;
        e_ok = 0;
        e_fail = 0;
        if (rs) begin
            mp = '0; mptr = 0; txn = 0; age = 0; acked = 0; msel = 0; mcost = 0;
            for (int k = 0; k < 4; k++) ml[k] = 0;
            return;
        end
        if (!txn) begin
            for (int k = 0; k < 4; k++) if (g < 0 && mp[(mptr + k) % 4]) g = (mptr + k) % 4;
            if (g >= 0) begin
                mp[g] = 1'b0;
                mptr = (g + 1) % 4;
                if (ml[g] == 3) e_fail = 1;
                else begin
                    txn = 1; age = 0; msel = g; e_purch = 1;
                    mcost = (BASE_T[g] << ml[g]) % 4096;
                end
            end
        end else if (acked) begin
            ml[msel] = (ml[msel] < 3) ? ml[msel] + 1 : 3;
            e_ok = 1; txn = 0; acked = 0; msel = 0; mcost = 0;
        end else if (age == 0) age = 1;
        else if (s) acked = 1;
        else if (age == TO) begin
            e_fail = 1; txn = 0; msel = 0; mcost = 0;
        end else age++;
        mp = mp | r;
    endtask

    task automatic cycle(input logic [3:0] r, input logic s, input logic rs);
        logic [7:0] lv;
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 4; k++) lv[2*k +: 2] = 2'(ml[k]);
        check("purchase", purchase, e_purch);
        check("buyOk", buyOk, e_ok);
        check("buyFail", buyFail, e_fail);
        check("busy", busy, txn);
        check("itemSel", itemSel, msel);
        check("unitCost", unitCost, mcost);
        check("levels", levels, lv);
        check("ok_fail_excl", buyOk & buyFail, 0);
        if (purchase === 1'b1) begin
            sel_q.push_back(int'(itemSel));
            cost_q.push_back(int'(unitCost));
            p_cyc = cyc;
        end
        if (buyFail === 1'b1) begin
            nfail++;
            f_cyc = cyc;
        end
        if (buyOk === 1'b1) nok++;
        req = r;
        buySucc = s;
        rst = rs;
        model_step(r, s, rs);
    endtask

    task automatic clear_logs();
        sel_q.delete();
        cost_q.delete();
        nfail = 0;
        nok = 0;
    endtask

    task automatic reset_dut();
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 1'b0);
        clear_logs();
    endtask

    task automatic buy(input int item, input int delay);
        cycle(4'(1 << item), 1'b0, 1'b0);
        repeat (2 + delay) cycle(4'b0000, 1'b0, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0);
        repeat (2) cycle(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic burst_order(input string tag);
        clear_logs();
        cycle(4'b1111, 1'b0, 1'b0);
        repeat (24) cycle(4'b0000, 1'b1, 1'b0);
        check({tag, "_n"}, sel_q.size(), 4);
        for (int i = 0; i < 4; i++) check({tag, "_sel"}, (i < sel_q.size()) ? sel_q[i] : -1, i);
    endtask

    initial begin
        int exp33 [3];
        exp33 = '{500, 1000, 2000};
        cyc = 0; p_cyc = 0; f_cyc = 0;
        req = 4'b0000; buySucc = 1'b0; rst = 1'b1;
        model_step(4'b0000, 1'b0, 1'b1);
        @(posedge clk);
        reset_dut();

        buy(0, 1);
        check("t032_n", cost_q.size(), 1);
        check("t032_cost", (cost_q.size() == 1) ? cost_q[0] : -1, 10);
        check("t032_lvl", levels[1:0], 1);
        check("t032_ok", nok, 1);

        reset_dut();
        repeat (3) buy(3, 0);
        check("t033_n", cost_q.size(), 3);
        for (int i = 0; i < 3; i++) check("t033_cost", (i < cost_q.size()) ? cost_q[i] : -1, exp33[i]);
        check("t033_lvl", levels[7:6], 3);
        clear_logs();
        buy(3, 0);
        check("t033_maxed_nobuy", cost_q.size(), 0);
        check("t033_maxed_fail", nfail, 1);

        reset_dut();
        burst_order("t034_a");
        burst_order("t034_b");

        reset_dut();
        buy(2, 10);
        repeat (6) cycle(4'b0000, 1'b0, 1'b0);
        check("t035_n", cost_q.size(), 1);
        check("t035_fail", nfail, 1);
        check("t035_ok", nok, 0);
        check("t035_delay", f_cyc - p_cyc, TO + 1);
        check("t035_lvl", levels, 0);

        reset_dut();
        cycle(4'b0001, 1'b0, 1'b0);
        repeat (3) cycle(4'b0000, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0000, 1'b1, 1'b0);
        repeat (3) cycle(4'b0000, 1'b0, 1'b0);
        check("t036_ok", nok, 0);
        check("t036_lvl", levels, 0);
        check("t036_busy", busy, 0);

        reset_dut();
        cycle(4'b0010, 1'b0, 1'b0);
        cycle(4'b0010, 1'b0, 1'b0);
        repeat (2) cycle(4'b0000, 1'b0, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0);
        repeat (12) cycle(4'b0000, 1'b1, 1'b0);
        check("t037_n", sel_q.size(), 2);
        for (int i = 0; i < 2; i++) check("t037_sel", (i < sel_q.size()) ? sel_q[i] : -1, 1);
        check("t037_ok", nok, 2);

        reset_dut();
        repeat (4000) begin
            logic [3:0] r;
            r = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
            cycle(r, $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
